// File: rtl/resource_lock_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// resource_lock_arbiter_pkg
// Shared types and helpers for the resource lock arbiter.
//   lock_req_t : one port's request as seen by the arbiter {req, id}.
//                The id field is sized for issue IDs up to 32 bits; narrower
//                IDs are zero-extended into it.
//   idx_width  : index width for a table of n entries, never less than 1.
// -----------------------------------------------------------------------------
package resource_lock_arbiter_pkg;

    localparam int LOCK_ID_MAX_W = 32;

    typedef struct packed {
        logic                     req;
        logic [LOCK_ID_MAX_W-1:0] id;
    } lock_req_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resource_lock_arbiter_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Combinational rotate-priority search: returns the first set bit of cand
// at or after position ptr, wrapping modulo N.
//   cand  in  N  candidate bitmap
//   ptr   in  W  starting position (must be < N)
//   found out 1  at least one candidate was set
//   idx   out W  index of the chosen candidate, 0 when none found
// -----------------------------------------------------------------------------
module rr_priority_picker
    import resource_lock_arbiter_pkg::*;
#(
    parameter int N = 8,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int pos;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = W'(pos);
            end
        end
    end

endmodule

// File: rtl/resource_lock_arbiter.sv
// -----------------------------------------------------------------------------
// resource_lock_arbiter
// Round-robin lock arbiter sharing NUM_UNITS pooled resources among NUM_PORTS
// controllers. A lock is bound to the issue ID latched at grant time, so a
// port that moves on to a new instruction drops its old lock automatically.
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   port_req    in   NUM_PORTS          request / hold a unit
//   port_id     in   ID_WIDTH x NUM_PORTS issue ID currently on each port
//   flush       in   1        drop every lock at the next edge
//   port_grant  out  NUM_PORTS          unit locked to this port (registered)
//   port_unit   out  UNIT_W x NUM_PORTS  locked unit index, 0 when not granted
//   unit_busy   out  NUM_UNITS          per-unit lock bitmap
//   unit_owner  out  PORT_W x NUM_UNITS  owning port, 0 when free
// -----------------------------------------------------------------------------
module resource_lock_arbiter
    import resource_lock_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 8,
    parameter int NUM_UNITS = 8,
    parameter int ID_WIDTH  = 16,
    localparam int UNIT_W   = idx_width(NUM_UNITS),
    localparam int PORT_W   = idx_width(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] port_req,
    input  logic [ID_WIDTH-1:0]  port_id [NUM_PORTS],
    input  logic                 flush,
    output logic [NUM_PORTS-1:0] port_grant,
    output logic [UNIT_W-1:0]    port_unit [NUM_PORTS],
    output logic [NUM_UNITS-1:0] unit_busy,
    output logic [PORT_W-1:0]    unit_owner [NUM_UNITS]
);

    // Per-port and per-unit lock state
    logic [NUM_PORTS-1:0] locked;
    logic [UNIT_W-1:0]    lock_unit [NUM_PORTS];
    logic [ID_WIDTH-1:0]  owner_id  [NUM_PORTS];
    logic [NUM_UNITS-1:0] busy;
    logic [PORT_W-1:0]    owner     [NUM_UNITS];
    logic [PORT_W-1:0]    rr_ptr;

    lock_req_t            lreq      [NUM_PORTS];
    logic [NUM_PORTS-1:0] id_diff;
    logic [NUM_PORTS-1:0] rel;
    logic [NUM_PORTS-1:0] cand;
    logic [NUM_UNITS-1:0] unit_rel;

    logic [NUM_PORTS-1:0] cand_chain [NUM_UNITS+1];
    logic [NUM_UNITS-1:0] pick_found;
    logic [PORT_W-1:0]    pick_idx   [NUM_UNITS];
    logic [NUM_UNITS-1:0] alloc;

    logic [NUM_PORTS-1:0] grant_new;
    logic [UNIT_W-1:0]    grant_unit [NUM_PORTS];
    logic                 any_grant;
    logic [PORT_W-1:0]    last_port;
    logic [PORT_W-1:0]    rr_ptr_nxt;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            lreq[p].req = port_req[p];
            lreq[p].id  = LOCK_ID_MAX_W'(port_id[p]);
        end
    end

    // Release and candidacy. A port whose ID changed under a live lock is
    // both released and eligible for a fresh grant on the same edge; it can
    // only land on a unit that was already free, never on the one it drops.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            id_diff[p] = (lreq[p].id != LOCK_ID_MAX_W'(owner_id[p]));
            rel[p]     = locked[p] && (!lreq[p].req || id_diff[p] || flush);
            cand[p]    = !flush && lreq[p].req && (!locked[p] || id_diff[p]);
        end
    end

    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_rel[u] = busy[u] && rel[owner[u]];
        end
    end

    // Units are visited in ascending index order; each free unit takes the
    // next remaining candidate in round-robin order, which is the same as
    // walking ports from rr_ptr and handing out the lowest free unit.
    assign cand_chain[0] = cand;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_pick
        rr_priority_picker #(
            .N (NUM_PORTS),
            .W (PORT_W)
        ) u_picker (
            .cand  (cand_chain[u]),
            .ptr   (rr_ptr),
            .found (pick_found[u]),
            .idx   (pick_idx[u])
        );

        assign alloc[u] = !busy[u] && pick_found[u];
        assign cand_chain[u+1] = alloc[u]
                               ? (cand_chain[u] & ~(NUM_PORTS'(1) << pick_idx[u]))
                               : cand_chain[u];
    end

    always_comb begin
        grant_new = '0;
        any_grant = 1'b0;
        last_port = rr_ptr;
        for (int p = 0; p < NUM_PORTS; p++) begin
            grant_unit[p] = '0;
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (alloc[u]) begin
                grant_new[pick_idx[u]]  = 1'b1;
                grant_unit[pick_idx[u]] = UNIT_W'(u);
                any_grant               = 1'b1;
                last_port               = pick_idx[u];
            end
        end
    end

    // The highest allocated unit holds the last port in scan order.
    always_comb begin
        if (!any_grant) begin
            rr_ptr_nxt = rr_ptr;
        end else if (last_port == PORT_W'(NUM_PORTS - 1)) begin
            rr_ptr_nxt = '0;
        end else begin
            rr_ptr_nxt = last_port + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= '0;
            busy   <= '0;
            rr_ptr <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                lock_unit[p] <= '0;
                owner_id[p]  <= '0;
            end
            for (int u = 0; u < NUM_UNITS; u++) begin
                owner[u] <= '0;
            end
        end else begin
            rr_ptr <= rr_ptr_nxt;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant_new[p]) begin
                    locked[p]    <= 1'b1;
                    lock_unit[p] <= grant_unit[p];
                    owner_id[p]  <= lreq[p].id[ID_WIDTH-1:0];
                end else if (rel[p]) begin
                    locked[p]    <= 1'b0;
                    lock_unit[p] <= '0;
                end
            end
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (alloc[u]) begin
                    busy[u]  <= 1'b1;
                    owner[u] <= pick_idx[u];
                end else if (unit_rel[u]) begin
                    busy[u]  <= 1'b0;
                    owner[u] <= '0;
                end
            end
        end
    end

    assign port_grant = locked;
    assign unit_busy  = busy;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_unit[p] = lock_unit[p];
        end
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_owner[u] = owner[u];
        end
    end

endmodule

// File: tb/tb_resource_lock_arbiter.sv
module tb_resource_lock_arbiter;

    localparam int NP = 8;
    localparam int NU = 2;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [NP-1:0] port_req = '0;
    logic [IW-1:0] port_id [NP];
    logic [NP-1:0] port_grant;
    logic [0:0]    port_unit [NP];
    logic [NU-1:0] unit_busy;
    logic [2:0]    unit_owner [NU];

    resource_lock_arbiter #(
        .NUM_PORTS (NP),
        .NUM_UNITS (NU),
        .ID_WIDTH  (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_req   (port_req),
        .port_id    (port_id),
        .flush      (flush),
        .port_grant (port_grant),
        .port_unit  (port_unit),
        .unit_busy  (unit_busy),
        .unit_owner (unit_owner)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] grant;
        logic [7:0] units;
        logic [1:0] busy;
        logic [5:0] owners;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    // Reference model state
    logic          m_locked [NP];
    int            m_unit   [NP];
    logic [IW-1:0] m_oid    [NP];
    logic          m_busy   [NU];
    int            m_owner  [NU];
    int            m_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_locked[i] = 1'b0;
            m_unit[i]   = 0;
            m_oid[i]    = '0;
        end
        for (int k = 0; k < NU; k++) begin
            m_busy[k]  = 1'b0;
            m_owner[k] = 0;
        end
        m_ptr = 0;
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_step();
        logic rel  [NP];
        logic cand [NP];
        logic diff;
        int   free_q[$];
        int   pp;
        int   uu;
        int   new_ptr;
        for (int i = 0; i < NP; i++) begin
            diff    = (port_id[i] !== m_oid[i]);
            rel[i]  = m_locked[i] && (!port_req[i] || diff || flush);
            cand[i] = !flush && port_req[i] && (!m_locked[i] || diff);
        end
        for (int k = 0; k < NU; k++) begin
            if (!m_busy[k]) free_q.push_back(k);
        end
        for (int i = 0; i < NP; i++) begin
            if (rel[i]) begin
                m_busy[m_unit[i]]  = 1'b0;
                m_owner[m_unit[i]] = 0;
                m_locked[i]        = 1'b0;
                m_unit[i]          = 0;
            end
        end
        new_ptr = m_ptr;
        if (!flush) begin
            for (int k = 0; k < NP; k++) begin
                pp = (m_ptr + k) % NP;
                if (cand[pp] && free_q.size() > 0) begin
                    uu           = free_q.pop_front();
                    m_locked[pp] = 1'b1;
                    m_unit[pp]   = uu;
                    m_oid[pp]    = port_id[pp];
                    m_busy[uu]   = 1'b1;
                    m_owner[uu]  = pp;
                    new_ptr      = (pp + 1) % NP;
                end
            end
        end
        m_ptr = new_ptr;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e = '0;
        for (int i = 0; i < NP; i++) begin
            e.grant[i] = m_locked[i];
            e.units[i] = m_unit[i][0];
        end
        for (int k = 0; k < NU; k++) begin
            e.busy[k]         = m_busy[k];
            e.owners[k*3 +: 3] = 3'(m_owner[k]);
        end
        return e;
    endfunction

    function automatic exp_t dut_outputs();
        exp_t o;
        o = '0;
        o.grant = port_grant;
        for (int i = 0; i < NP; i++) o.units[i] = port_unit[i][0];
        o.busy = unit_busy;
        for (int k = 0; k < NU; k++) o.owners[k*3 +: 3] = unit_owner[k];
        return o;
    endfunction

    // Drive one edge: predict, queue the expectation, then compare after the edge.
    task automatic step(input string tag);
        exp_t e;
        exp_t o;
        model_step();
        exp_q.push_back(model_outputs());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        o = dut_outputs();
        check({tag, ".grant"},  32'(o.grant),  32'(e.grant));
        check({tag, ".unit"},   32'(o.units),  32'(e.units));
        check({tag, ".busy"},   32'(o.busy),   32'(e.busy));
        check({tag, ".owner"},  32'(o.owners), 32'(e.owners));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".grant"}, 32'(port_grant), 32'h0);
        check({tag, ".busy"},  32'(unit_busy),  32'h0);
        for (int i = 0; i < NP; i++) check({tag, ".unit"}, 32'(port_unit[i]), 32'h0);
        for (int k = 0; k < NU; k++) check({tag, ".owner"}, 32'(unit_owner[k]), 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        port_req = '0;
        flush    = 1'b0;
        for (int i = 0; i < NP; i++) port_id[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [NP-1:0] prev_grant;
    logic [NP-1:0] new_grant;
    int            order_q[$];

    initial begin
        for (int i = 0; i < NP; i++) port_id[i] = '0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single port hold
        port_id[3] = 16'h0010;
        port_req   = 8'h08;
        step("single.c1");
        check("single.grant", 32'(port_grant), 32'h08);
        check("single.unit3", 32'(port_unit[3]), 32'h0);
        check("single.busy", 32'(unit_busy), 32'h01);
        check("single.owner0", 32'(unit_owner[0]), 32'h3);
        for (int c = 2; c <= 4; c++) begin
            step("single.hold");
            check("single.hold_grant", 32'(port_grant[3]), 32'h1);
        end
        port_req = '0;
        step("single.drop");
        check("single.drop_grant", 32'(port_grant), 32'h0);

        // Contention with all units busy, then release and hand-over
        do_reset("rst.cont");
        port_req = 8'b0010_0011;
        step("cont.c1");
        check("cont.grant", 32'(port_grant), 32'h03);
        check("cont.unit1", 32'(port_unit[1]), 32'h1);
        step("cont.wait");
        check("cont.wait5", 32'(port_grant[5]), 32'h0);
        port_req[0] = 1'b0;
        step("cont.rel");
        check("cont.rel5", 32'(port_grant[5]), 32'h0);
        check("cont.rel_busy", 32'(unit_busy), 32'h2);
        step("cont.regrant");
        check("cont.grant5", 32'(port_grant[5]), 32'h1);
        check("cont.unit5", 32'(port_unit[5]), 32'h0);
        check("cont.owner0", 32'(unit_owner[0]), 32'h5);
        port_req = '0;
        step("cont.clear");

        // Fairness: everyone requests, each holds one cycle
        do_reset("rst.fair");
        prev_grant = '0;
        for (int c = 0; c < 9; c++) begin
            for (int i = 0; i < NP; i++) port_req[i] = !m_locked[i];
            step("fair");
            new_grant = port_grant & ~prev_grant;
            for (int i = 0; i < NP; i++) if (new_grant[i]) order_q.push_back(i);
            prev_grant = port_grant;
        end
        check("fair.count", 32'(order_q.size()), 32'd10);
        for (int k = 0; k < 10 && k < order_q.size(); k++) begin
            check("fair.order", 32'(order_q[k]), 32'(k % NP));
        end
        port_req = '0;
        step("fair.clear");

        // ID change under a live lock
        do_reset("rst.id");
        port_id[2] = 16'h0005;
        port_id[4] = 16'h0009;
        port_req   = 8'h14;
        step("id.c1");
        check("id.grant", 32'(port_grant), 32'h14);
        check("id.unit2", 32'(port_unit[2]), 32'h0);
        port_id[2] = 16'h0006;
        step("id.change");
        check("id.rel2", 32'(port_grant[2]), 32'h0);
        check("id.rel_busy", 32'(unit_busy), 32'h2);
        step("id.regrant");
        check("id.grant2", 32'(port_grant[2]), 32'h1);
        check("id.unit2b", 32'(port_unit[2]), 32'h0);
        step("id.hold");
        check("id.hold2", 32'(port_grant[2]), 32'h1);
        port_req = '0;
        step("id.clear");

        // Flush with a waiting requester; re-grant wraps the pointer
        do_reset("rst.flush");
        port_req = 8'b0100_1010;
        step("flush.c1");
        check("flush.grant", 32'(port_grant), 32'h0A);
        check("flush.unit3", 32'(port_unit[3]), 32'h1);
        flush = 1'b1;
        step("flush.edge");
        check("flush.grant0", 32'(port_grant), 32'h0);
        check("flush.busy0", 32'(unit_busy), 32'h0);
        flush = 1'b0;
        step("flush.after");
        check("flush.regrant", 32'(port_grant), 32'h42);
        check("flush.unit6", 32'(port_unit[6]), 32'h0);
        check("flush.unit1", 32'(port_unit[1]), 32'h1);
        check("flush.owner1", 32'(unit_owner[1]), 32'h1);

        // Asynchronous reset while locks are held
        check("areset.pre", 32'(unit_busy), 32'h3);
        do_reset("areset");

        // Random traffic against the model
        for (int c = 0; c < 300; c++) begin
            port_req = 8'($urandom);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 7) == 0) port_id[i] = 16'($urandom_range(0, 1));
            end
            flush = ($urandom_range(0, 15) == 0);
            step("rand");
        end
        flush    = 1'b0;
        port_req = '0;
        step("rand.clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
